// File: rtl/instruction_prefetch.sv
// In-order instruction fetch unit with a credit-limited prefetch queue.
// Redirects and flushes discard both queued and in-flight responses.
module instruction_prefetch #(
   parameter int                IWIDTH       = 32,
   parameter int                AWIDTH_INSTR = 32,
   parameter int                PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int                QDEPTH       = 4
) (
   input  logic                    f_clk,
   input  logic                    f_rst,
   output logic                    f_o_syn,
   output logic [PC_WIDTH-1:0]     f_o_req_addr,
   input  logic                    f_i_req_rdy,
   input  logic                    f_i_ack,
   input  logic [IWIDTH-1:0]       f_i_instr,
   output logic [PC_WIDTH-1:0]     f_pc,
   input  logic                    f_change_pc,
   input  logic [PC_WIDTH-1:0]     f_alu_pc_value,
   input  logic                    f_i_flush,
   output logic                    f_o_flush,
   output logic                    f_o_ce,
   output logic [IWIDTH-1:0]       f_o_instr,
   output logic [AWIDTH_INSTR-1:0] f_o_addr_instr,
   input  logic                    f_i_stall,
   output logic                    f_o_stall
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   logic                    run;
   logic [PC_WIDTH-1:0]     pc_q;
   logic [PC_WIDTH-1:0]     resp_pc;
   logic [CW-1:0]           rd_ptr;
   logic [CW-1:0]           wr_ptr;
   logic [CW-1:0]           count;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           drop;
   logic                    flush_q;
   logic [IWIDTH-1:0]       q_data [QDEPTH];
   logic [AWIDTH_INSTR-1:0] q_addr [QDEPTH];

   logic [CW:0]             credit;
   logic                    kill;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic [PC_WIDTH-1:0]     target;

   // Each issued request reserves a queue slot, so pushes never overflow.
   assign credit  = {1'b0, count} + {1'b0, inflight};
   assign kill    = f_change_pc || f_i_flush;
   assign f_o_syn = run && !kill && (credit < (CW+1)'(QDEPTH));
   assign accept  = f_o_syn && f_i_req_rdy;
   assign push    = f_i_ack && (drop == '0) && !kill;
   assign pop     = (count != '0) && !f_i_stall && !kill;
   assign target  = f_alu_pc_value & ~PC_WIDTH'(3);

   assign f_o_req_addr   = pc_q;
   assign f_pc           = pc_q;
   assign f_o_flush      = flush_q;
   assign f_o_ce         = (count != '0);
   assign f_o_stall      = (count == '0) && run;
   assign f_o_instr      = q_data[rd_ptr[AW-1:0]];
   assign f_o_addr_instr = q_addr[rd_ptr[AW-1:0]];

   always_ff @(posedge f_clk) begin
      if (f_rst) begin
         run      <= 1'b1;
         pc_q     <= RESET_PC;
         resp_pc  <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         drop     <= '0;
         flush_q  <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_data[i] <= '0;
            q_addr[i] <= '0;
         end
      end else begin
         flush_q <= kill;
         if (kill) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // Everything still outstanding after this cycle's ack is stale.
            inflight <= inflight - CW'(f_i_ack);
            drop     <= inflight - CW'(f_i_ack);
            if (f_change_pc) begin
               pc_q    <= target;
               resp_pc <= target;
               run     <= 1'b1;
            end else begin
               run <= 1'b0;
            end
         end else begin
            if (accept)
               pc_q <= pc_q + PC_WIDTH'(4);
            inflight <= inflight + CW'(accept) - CW'(f_i_ack);
            if (f_i_ack && (drop != '0))
               drop <= drop - CW'(1);
            if (push) begin
               q_data[wr_ptr[AW-1:0]] <= f_i_instr;
               q_addr[wr_ptr[AW-1:0]] <= resp_pc[AWIDTH_INSTR-1:0];
               wr_ptr  <= wr_ptr + CW'(1);
               resp_pc <= resp_pc + PC_WIDTH'(4);
            end
            if (pop)
               rd_ptr <= rd_ptr + CW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

endmodule
